// File: rtl/seg_scan_drv.sv
// Four-digit multiplexed 7-segment driver, scanned by rising edges of clk_1K.
// Digit data is frame-latched on the 3->0 wrap; a guard interval blanks anodes after each digit change.
module seg_scan_drv #(
  parameter int unsigned GUARD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_1K,
  input  logic [15:0] data,
  input  logic [3:0]  dp_en,
  input  logic [3:0]  blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int unsigned NDIG = 4;
  localparam int unsigned IDXW = 2;
  localparam int unsigned SEGW = 7;
  localparam int unsigned DATW = 4 * NDIG;
  localparam int unsigned GW   = (GUARD < 2) ? 1 : $clog2(GUARD + 1);

  logic            clk_1k_d_q, clk_1k_d_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [GW-1:0]   guard_q, guard_d;
  logic [DATW-1:0] data_lat_q, data_lat_d;
  logic [NDIG-1:0] dp_lat_q, dp_lat_d;
  logic [NDIG-1:0] blank_lat_q, blank_lat_d;
  logic [NDIG-1:0] an_q, an_d;
  logic [SEGW-1:0] seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            frame_start_q, frame_start_d;
  logic            rise_c;

  // Hex digit to active-low gfedcba pattern
  function automatic logic [SEGW-1:0] hex_to_seg(input logic [3:0] h);
    logic [SEGW-1:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign rise_c = clk_1K & ~clk_1k_d_q;

  // Next-state: scan advance, frame latch, guard countdown, registered decode
  always_comb begin
    clk_1k_d_d    = clk_1K;
    idx_d         = idx_q;
    guard_d       = guard_q;
    data_lat_d    = data_lat_q;
    dp_lat_d      = dp_lat_q;
    blank_lat_d   = blank_lat_q;
    seg_d         = seg_q;
    dp_d          = dp_q;
    frame_start_d = 1'b0;

    if (rise_c) begin
      idx_d   = idx_q + IDXW'(1);
      guard_d = GW'(GUARD);
      if (idx_q == IDXW'(NDIG - 1)) begin
        data_lat_d    = data;
        dp_lat_d      = dp_en;
        blank_lat_d   = blank;
        frame_start_d = 1'b1;
      end
      seg_d = hex_to_seg(data_lat_d[{idx_d, 2'b00} +: 4]);
      dp_d  = ~dp_lat_d[idx_d];
    end else if (guard_q != '0) begin
      guard_d = guard_q - GW'(1);
    end

    // Anode follows the post-edge guard count so GUARD=0 lights on the tick itself
    if ((guard_d != '0) || blank_lat_d[idx_d]) begin
      an_d = 4'b1111;
    end else begin
      an_d = ~(4'b0001 << idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_1k_d_q    <= 1'b0;
      idx_q         <= IDXW'(NDIG - 1);
      guard_q       <= '0;
      data_lat_q    <= '0;
      dp_lat_q      <= '0;
      blank_lat_q   <= '1;
      an_q          <= '1;
      seg_q         <= '1;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      clk_1k_d_q    <= clk_1k_d_d;
      idx_q         <= idx_d;
      guard_q       <= guard_d;
      data_lat_q    <= data_lat_d;
      dp_lat_q      <= dp_lat_d;
      blank_lat_q   <= blank_lat_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Scoreboard bench for seg_scan_drv: one instance with GUARD=4 and one with GUARD=0 share all inputs.
module tb_seg_scan_drv;

  localparam int unsigned G = 4;

  logic        clk = 1'b0;
  logic        reset, clk_1K;
  logic [15:0] data;
  logic [3:0]  dp_en, blank;
  logic [3:0]  an_g, an_z;
  logic [6:0]  seg_g, seg_z;
  logic        dp_g, dp_z, fs_g, fs_z;

  always #5 clk = ~clk;

  seg_scan_drv #(.GUARD(G)) u_dut_g (
    .clk(clk), .reset(reset), .clk_1K(clk_1K), .data(data), .dp_en(dp_en), .blank(blank),
    .an(an_g), .seg(seg_g), .dp(dp_g), .frame_start(fs_g)
  );

  seg_scan_drv #(.GUARD(0)) u_dut_z (
    .clk(clk), .reset(reset), .clk_1K(clk_1K), .data(data), .dp_en(dp_en), .blank(blank),
    .an(an_z), .seg(seg_z), .dp(dp_z), .frame_start(fs_z)
  );

  typedef struct {
    int         due;
    int         sel;
    logic [6:0] exp;
  } exp_t;

  exp_t       sb_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  logic [6:0] hex_tab [16];

  // Expected display state, tracked at the level of scan ticks and frames
  int          m_idx, m_since;
  logic [15:0] m_dlat;
  logic [3:0]  m_dplat, m_blat;
  logic [6:0]  m_seg;
  logic        m_dp, m_fs, m_prev;

  task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, obs, exp);
    end
  endtask

  function automatic void push(input int sel, input logic [6:0] exp);
    exp_t e;
    e.due = cyc + 1;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endfunction

  // Predict the outputs after the coming clock edge and queue them
  function automatic void model_edge();
    logic [15:0] sh;
    logic [3:0]  on, an_ge, an_ze;
    if (reset) begin
      m_idx = 3; m_dlat = '0; m_dplat = '0; m_blat = 4'hF;
      m_seg = 7'h7F; m_dp = 1'b1; m_fs = 1'b0; m_since = 1000; m_prev = 1'b0;
    end else begin
      if (clk_1K && !m_prev) begin
        m_idx = (m_idx + 1) % 4;
        m_fs  = (m_idx == 0);
        if (m_fs) begin
          m_dlat = data; m_dplat = dp_en; m_blat = blank;
        end
        m_since = 0;
        sh    = m_dlat >> (4 * m_idx);
        m_seg = hex_tab[sh[3:0]];
        m_dp  = ~m_dplat[m_idx];
      end else begin
        m_fs = 1'b0;
        if (m_since < 1000) m_since++;
      end
      m_prev = clk_1K;
    end
    on    = m_blat[m_idx] ? 4'hF : ~(4'b0001 << m_idx);
    an_ge = (m_since < int'(G)) ? 4'hF : on;
    an_ze = on;
    push(0, {3'b000, an_ge});
    push(1, {3'b000, an_ze});
    push(2, m_seg);
    push(3, m_seg);
    push(4, {6'b0, m_dp});
    push(5, {6'b0, m_dp});
    push(6, {6'b0, m_fs});
    push(7, {6'b0, m_fs});
  endfunction

  // Advance one clock, sample #1 after the edge, retire every due expectation
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      case (e.sel)
        0: check_val("an_g4",  {3'b000, an_g}, e.exp);
        1: check_val("an_g0",  {3'b000, an_z}, e.exp);
        2: check_val("seg_g4", seg_g, e.exp);
        3: check_val("seg_g0", seg_z, e.exp);
        4: check_val("dp_g4",  {6'b0, dp_g}, e.exp);
        5: check_val("dp_g0",  {6'b0, dp_z}, e.exp);
        6: check_val("fs_g4",  {6'b0, fs_g}, e.exp);
        default: check_val("fs_g0", {6'b0, fs_z}, e.exp);
      endcase
    end
  endtask

  task automatic drive(input logic r, input logic k);
    reset  = r;
    clk_1K = k;
    model_edge();
    step();
  endtask

  task automatic half(input logic k, input int n);
    repeat (n) drive(1'b0, k);
  endtask

  task automatic period();
    half(1'b1, 20);
    half(1'b0, 20);
  endtask

  initial begin
    hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    reset = 1'b1; clk_1K = 1'b0;
    data = 16'h1234; dp_en = 4'b0000; blank = 4'b0000;

    // Reset held with clk_1K toggling: dark, no frame pulses
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    half(1'b0, 5);

    // Frame 1: digit 0 then digit 1, inputs changed mid-frame
    period();
    half(1'b1, 10);
    data = 16'hABCD; blank = 4'b1000; dp_en = 4'b0001;
    half(1'b1, 10);
    half(1'b0, 20);
    period();
    period();

    // Frame 2 shows the new data, blank and decimal point
    repeat (4) period();

    // clk_1K held high: exactly one tick
    half(1'b1, 100);
    half(1'b0, 20);

    // Reset while digit 2 is selected, released with clk_1K low
    period();
    half(1'b1, 10);
    drive(1'b1, 1'b0);
    half(1'b0, 10);
    period();
    period();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
